// File: rtl/semester_pkg.sv
// semester_pkg: shared state encoding and widths for the semester tracker
package semester_pkg;
   localparam int CREDIT_W = 6;
   localparam int DAY_W    = 5;
   localparam int STREAK_W = 3;
   localparam logic [CREDIT_W-1:0] CREDIT_MAX = 6'd63;
   typedef enum logic [1:0] {IDLE, RUN, GRAD, DROP} state_e;
endpackage

// File: rtl/credit_accum.sv
// credit_accum: next credit value for one day result, saturating at CREDIT_MAX
module credit_accum
   import semester_pkg::*;
(
   input  logic [CREDIT_W-1:0] credits_i,
   input  logic                day_pass_i,
   input  logic [1:0]          day_bonus_i,
   output logic [CREDIT_W-1:0] credits_o
);
   logic [CREDIT_W:0] sum;
   // one extra bit catches overflow before saturating
   always_comb begin
      sum       = {1'b0, credits_i} + (CREDIT_W+1)'(day_bonus_i) + (CREDIT_W+1)'(1);
      credits_o = !day_pass_i ? credits_i : sum > {1'b0, CREDIT_MAX} ? CREDIT_MAX : sum[CREDIT_W-1:0];
   end
endmodule

// File: rtl/semester_tracker.sv
// semester_tracker: accumulates daily results into a graduate / drop-out verdict
module semester_tracker
   import semester_pkg::*;
#(
   parameter int unsigned NUM_DAYS        = 16,
   parameter int unsigned CREDIT_GOAL     = 20,
   parameter int unsigned MAX_FAIL_STREAK = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                day_valid,
   input  logic                day_pass,
   input  logic [1:0]          day_bonus,
   output logic                day_ready,
   output logic [CREDIT_W-1:0] credits,
   output logic [STREAK_W-1:0] fail_streak,
   output logic [DAY_W-1:0]    days_used,
   output logic                busy,
   output logic                graduated,
   output logic                dropped_out
);
   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credits_q, credits_d, credits_acc;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic [DAY_W-1:0]    days_q, days_d;
   logic                accept;

   credit_accum u_acc (
      .credits_i   (credits_q),
      .day_pass_i  (day_pass),
      .day_bonus_i (day_bonus),
      .credits_o   (credits_acc)
   );

   // state and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         credits_q <= '0;
         streak_q  <= '0;
         days_q    <= '0;
      end else begin
         state_q   <= state_d;
         credits_q <= credits_d;
         streak_q  <= streak_d;
         days_q    <= days_d;
      end
   end

   // next state: start opens a semester, each accepted day may close it with a verdict
   always_comb begin
      accept    = day_valid && state_q == RUN;
      state_d   = state_q;
      credits_d = credits_q;
      streak_d  = streak_q;
      days_d    = days_q;
      if (state_q != RUN && start) begin
         state_d   = RUN;
         credits_d = '0;
         streak_d  = '0;
         days_d    = '0;
      end else if (accept) begin
         credits_d = credits_acc;
         streak_d  = day_pass ? '0 : streak_q + STREAK_W'(1);
         days_d    = days_q + DAY_W'(1);
         state_d   = credits_d >= CREDIT_W'(CREDIT_GOAL) ? GRAD :
                     (streak_d == STREAK_W'(MAX_FAIL_STREAK) || days_d == DAY_W'(NUM_DAYS)) ? DROP : RUN;
      end
   end

   // outputs decoded from registered state
   always_comb begin
      busy        = state_q == RUN;
      day_ready   = state_q == RUN;
      graduated   = state_q == GRAD;
      dropped_out = state_q == DROP;
      credits     = credits_q;
      fail_streak = streak_q;
      days_used   = days_q;
   end
endmodule

// File: tb/tb_semester_tracker.sv
// tb_semester_tracker: directed vector bench for semester_tracker
module tb_semester_tracker;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0, day_valid = 1'b0, day_pass = 1'b0;
   logic [1:0] day_bonus = 2'd0;
   logic       day_ready, busy, graduated, dropped_out;
   logic [5:0] credits;
   logic [2:0] fail_streak;
   logic [4:0] days_used;
   logic [5:0] ca_c, ca_o;
   logic       ca_p;
   logic [1:0] ca_b;
   int         total = 0, bad = 0;

   typedef struct packed {
      logic       st, v, p;
      logic [1:0] b;
      logic [5:0] c;
      logic [2:0] s;
      logic [4:0] d;
      logic       bz, g, dr;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   semester_tracker dut (
      .clk(clk), .rst_n(rst_n), .start(start), .day_valid(day_valid),
      .day_pass(day_pass), .day_bonus(day_bonus), .day_ready(day_ready),
      .credits(credits), .fail_streak(fail_streak), .days_used(days_used),
      .busy(busy), .graduated(graduated), .dropped_out(dropped_out)
   );

   credit_accum u_ca (.credits_i(ca_c), .day_pass_i(ca_p), .day_bonus_i(ca_b), .credits_o(ca_o));

   function automatic void add(int st, int v, int p, int b, int c, int s, int d, int bz, int g, int dr);
      vec_t x;
      x.st = st[0]; x.v = v[0]; x.p = p[0]; x.b = b[1:0];
      x.c = c[5:0]; x.s = s[2:0]; x.d = d[4:0];
      x.bz = bz[0]; x.g = g[0]; x.dr = dr[0];
      tbl.push_back(x);
   endfunction

   task automatic chk(string nm, logic [17:0] want);
      logic [17:0] got;
      got = {credits, fail_streak, days_used, busy, day_ready, graduated, dropped_out};
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got c=%0d s=%0d d=%0d bz=%b rdy=%b g=%b dr=%b want c=%0d s=%0d d=%0d bz=%b rdy=%b g=%b dr=%b",
                  nm, got[17:12], got[11:9], got[8:4], got[3], got[2], got[1], got[0],
                  want[17:12], want[11:9], want[8:4], want[3], want[2], want[1], want[0]);
      end
   endtask

   task automatic apply(vec_t x, string nm);
      start = x.st; day_valid = x.v; day_pass = x.p; day_bonus = x.b;
      @(posedge clk);
      #1;
      chk(nm, {x.c, x.s, x.d, x.bz, x.bz, x.g, x.dr});
   endtask

   initial begin
      vec_t h;
      #2 rst_n = 1'b0;
      #10;
      chk("reset_state", 18'd0);
      @(negedge clk) rst_n = 1'b1;
      // hand sequence: reach credits=7 days=4, then reset mid-cycle
      h = '{1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b0}; apply(h, "hs_start");
      h = '{1'b0, 1'b1, 1'b1, 2'd1, 6'd2, 3'd0, 5'd1, 1'b1, 1'b0, 1'b0}; apply(h, "hs_d1");
      h = '{1'b0, 1'b1, 1'b1, 2'd1, 6'd4, 3'd0, 5'd2, 1'b1, 1'b0, 1'b0}; apply(h, "hs_d2");
      h = '{1'b0, 1'b1, 1'b1, 2'd1, 6'd6, 3'd0, 5'd3, 1'b1, 1'b0, 1'b0}; apply(h, "hs_d3");
      h = '{1'b0, 1'b1, 1'b1, 2'd0, 6'd7, 3'd0, 5'd4, 1'b1, 1'b0, 1'b0}; apply(h, "hs_d4");
      day_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("async_reset_mid_run", 18'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", 18'd0);

      // day_valid without start: nothing accepted
      add(0,1,1,3, 0,0,0, 0,0,0);
      add(1,0,0,0, 0,0,0, 1,0,0);
      // graduation with bonus 3 each day
      for (int k = 1; k <= 5; k++) add(0,1,1,3, 4*k,0,k, k<5,k==5,0);
      add(0,1,1,3, 20,0,5, 0,1,0);
      add(1,1,0,0, 0,0,0, 1,0,0);
      // streak drop, start ignored in RUN, idle cycles hold
      add(0,1,1,0, 1,0,1, 1,0,0);
      add(1,1,0,2, 1,1,2, 1,0,0);
      add(0,1,1,0, 2,0,3, 1,0,0);
      add(0,1,0,0, 2,1,4, 1,0,0);
      for (int k = 0; k < 3; k++) add(0,0,1,3, 2,1,4, 1,0,0);
      add(1,1,0,0, 2,2,5, 1,0,0);
      add(0,1,0,0, 2,3,6, 0,0,1);
      add(0,1,1,3, 2,3,6, 0,0,1);
      add(1,0,0,0, 0,0,0, 1,0,0);
      // day limit with alternating pass/fail
      for (int k = 1; k <= 16; k++) add(0,1,k%2,0, (k+1)/2,(k%2)?0:1,k, k<16,0,k==16);
      add(1,0,0,0, 0,0,0, 1,0,0);
      // 16th day reaches the goal: graduation wins over day limit
      for (int k = 1; k <= 15; k++) add(0,1,k%2,1, 2*((k+1)/2),(k%2)?0:1,k, 1,0,0);
      add(0,1,1,3, 20,0,16, 0,1,0);

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

      // saturation boundary of the credit adder
      begin
         int cs[6][4] = '{'{62,1,3,63}, '{60,1,3,63}, '{59,1,3,63}, '{58,1,3,62}, '{63,0,3,63}, '{10,1,2,13}};
         for (int i = 0; i < 6; i++) begin
            ca_c = cs[i][0][5:0]; ca_p = cs[i][1][0]; ca_b = cs[i][2][1:0];
            #1;
            total++;
            if (ca_o !== cs[i][3][5:0]) begin
               bad++;
               $display("FAIL accum%0d: got %0d want %0d", i, ca_o, cs[i][3]);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
